// File: rtl/issue_queue_pkg.sv
// Shared issue-queue defines: element width, default depth and the occupancy width.
// Consumed by issue_queue and by the issue stage that reads issue_require.
package issue_queue_pkg;

    localparam int ISSUE_QUEUE_ELEMENT = 32;
    localparam int IQ_DEPTH_DEFAULT    = 16;
    localparam int IQ_ADDR             = $clog2(IQ_DEPTH_DEFAULT) + 1;

    typedef logic [ISSUE_QUEUE_ELEMENT-1:0] iq_element_t;

endpackage

// File: rtl/issue_queue.sv
// In-order dual-push / dual-pop ring buffer between decode and issue.
// Optional statistics counters are built when ISSUE_QUEUE_STAT_EN is defined.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int IQ_DEPTH = IQ_DEPTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [1:0]                    push_number,
    input  iq_element_t [1:0]             push_data,
    output logic                          iq_ready,
    output iq_element_t [1:0]             issue_require,
    output logic [$clog2(IQ_DEPTH):0]     iq_size,
`ifdef ISSUE_QUEUE_STAT_EN
    output logic [31:0]                   stat_full_cycles,
    output logic [31:0]                   stat_issued,
`endif
    input  logic [1:0]                    iq_pop_number
);

    localparam int PTR_W = $clog2(IQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    iq_element_t      r_mem [IQ_DEPTH];

    logic [1:0]       w_push;
    logic [1:0]       w_pop_req;
    logic [1:0]       w_pop;
    logic [PTR_W-1:0] w_head1;
    logic [PTR_W-1:0] w_tail1;

    assign iq_ready = (r_count <= CNT_W'(IQ_DEPTH - 2));
    assign iq_size  = r_count;
    assign w_head1  = r_head + PTR_W'(1);
    assign w_tail1  = r_tail + PTR_W'(1);

    // Effective push/pop after clamping; a flush cycle does neither.
    always_comb begin
        w_push    = 2'd0;
        w_pop_req = (iq_pop_number == 2'd3) ? 2'd2 : iq_pop_number;
        w_pop     = 2'd0;
        if (!flush) begin
            if (iq_ready) begin
                w_push = (push_number == 2'd3) ? 2'd2 : push_number;
            end
            if (r_count < CNT_W'(w_pop_req)) begin
                w_pop = r_count[1:0];
            end else begin
                w_pop = w_pop_req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_pop);
            r_tail  <= r_tail + PTR_W'(w_push);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push != 2'd0) begin
            r_mem[r_tail] <= push_data[0];
        end
        if (w_push == 2'd2) begin
            r_mem[w_tail1] <= push_data[1];
        end
    end

    always_comb begin
        issue_require[0] = '0;
        issue_require[1] = '0;
        if (r_count >= CNT_W'(1)) begin
            issue_require[0] = r_mem[r_head];
        end
        if (r_count >= CNT_W'(2)) begin
            issue_require[1] = r_mem[w_head1];
        end
    end

`ifdef ISSUE_QUEUE_STAT_EN
    logic [31:0] r_full_cycles;
    logic [31:0] r_issued;
    logic [32:0] w_issued_sum;

    assign w_issued_sum     = {1'b0, r_issued} + 33'(w_pop);
    assign stat_full_cycles = r_full_cycles;
    assign stat_issued      = r_issued;

    // Saturating counters that survive flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full_cycles <= '0;
            r_issued      <= '0;
        end else begin
            if (!iq_ready && (r_full_cycles != '1)) begin
                r_full_cycles <= r_full_cycles + 32'd1;
            end
            r_issued <= w_issued_sum[32] ? '1 : w_issued_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_issue_queue.sv
// Randomised self-checking bench for issue_queue against a queue-based reference model.
// Builds with or without ISSUE_QUEUE_STAT_EN.
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int DEPTH = 16;

    logic              clk;
    logic              rst;
    logic              flush;
    logic [1:0]        push_number;
    iq_element_t [1:0] push_data;
    logic              iq_ready;
    iq_element_t [1:0] issue_require;
    logic [4:0]        iq_size;
    logic [1:0]        iq_pop_number;
`ifdef ISSUE_QUEUE_STAT_EN
    logic [31:0]       stat_full_cycles;
    logic [31:0]       stat_issued;
`endif

    int errCount   = 0;
    int checkCount = 0;

    issue_queue #(.IQ_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .push_number   (push_number),
        .push_data     (push_data),
        .iq_ready      (iq_ready),
        .issue_require (issue_require),
        .iq_size       (iq_size),
`ifdef ISSUE_QUEUE_STAT_EN
        .stat_full_cycles (stat_full_cycles),
        .stat_issued      (stat_issued),
`endif
        .iq_pop_number (iq_pop_number)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the queue contents in age order, front = oldest.
    logic [31:0] mq[$];
    int          mP;
    int          mQ;
    longint      mFull;
    longint      mIssued;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            mFull   = 0;
            mIssued = 0;
        end else begin
            if (DEPTH - mq.size() < 2) mFull = mFull + 1;
            if (flush) begin
                mq.delete();
            end else begin
                mP = (push_number > 2) ? 2 : int'(push_number);
                if (DEPTH - mq.size() < 2) mP = 0;
                mQ = (iq_pop_number > 2) ? 2 : int'(iq_pop_number);
                if (mQ > mq.size()) mQ = mq.size();
                mIssued = mIssued + mQ;
                for (int i = 0; i < mQ; i++) void'(mq.pop_front());
                for (int i = 0; i < mP; i++) mq.push_back(push_data[i]);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare process: outputs are registered, so sample on the falling edge.
    always @(negedge clk) begin
        checkOutput("cmp_size", 32'(iq_size), 32'(mq.size()));
        checkOutput("cmp_ready", 32'(iq_ready), 32'((DEPTH - mq.size()) >= 2));
        checkOutput("cmp_req0", issue_require[0], (mq.size() > 0) ? mq[0] : 32'd0);
        checkOutput("cmp_req1", issue_require[1], (mq.size() > 1) ? mq[1] : 32'd0);
`ifdef ISSUE_QUEUE_STAT_EN
        checkOutput("cmp_stat_full", stat_full_cycles, 32'(mFull));
        checkOutput("cmp_stat_issued", stat_issued, 32'(mIssued));
`endif
    end

    task automatic applyStimulus(input int pn, input logic [31:0] d0, input logic [31:0] d1,
                                 input int qn, input logic fl);
        push_number   = 2'(pn);
        push_data[0]  = d0;
        push_data[1]  = d1;
        iq_pop_number = 2'(qn);
        flush         = fl;
        @(posedge clk);
        #1;
        push_number   = 2'd0;
        iq_pop_number = 2'd0;
        flush         = 1'b0;
    endtask

    task automatic pinState(input string name, input int size, input logic rdy,
                            input logic [31:0] r0, input logic [31:0] r1);
        checkOutput({name, "_size"}, 32'(iq_size), 32'(size));
        checkOutput({name, "_ready"}, 32'(iq_ready), 32'(rdy));
        checkOutput({name, "_req0"}, issue_require[0], r0);
        checkOutput({name, "_req1"}, issue_require[1], r1);
    endtask

    logic [31:0] seq;

    initial begin
        rst = 1'b0; flush = 1'b0; push_number = 2'd0; iq_pop_number = 2'd0;
        push_data[0] = '0; push_data[1] = '0;
        seq = 32'h100;
        repeat (3) @(posedge clk);
        #1;
        pinState("reset", 0, 1'b1, 32'd0, 32'd0);
        rst = 1'b1;

        // Push A,B then pop one.
        applyStimulus(2, 32'hAAAA0001, 32'hBBBB0002, 0, 1'b0);
        pinState("t1_push", 2, 1'b1, 32'hAAAA0001, 32'hBBBB0002);
        applyStimulus(0, 32'd0, 32'd0, 1, 1'b0);
        pinState("t1_pop", 1, 1'b1, 32'hBBBB0002, 32'd0);
        applyStimulus(0, 32'd0, 32'd0, 2, 1'b0);
        pinState("t1_drain", 0, 1'b1, 32'd0, 32'd0);

        // Fill to the ready threshold and beyond.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(2, seq, seq + 1, 0, 1'b0);
            seq = seq + 2;
        end
        checkOutput("t2_size14", 32'(iq_size), 32'd14);
        checkOutput("t2_ready14", 32'(iq_ready), 32'd1);
        applyStimulus(1, seq, 32'hDEAD, 0, 1'b0);
        seq = seq + 1;
        checkOutput("t2_size15", 32'(iq_size), 32'd15);
        checkOutput("t2_ready15", 32'(iq_ready), 32'd0);
        applyStimulus(2, 32'hDEAD0000, 32'hDEAD0001, 0, 1'b0);
        checkOutput("t2_ignored", 32'(iq_size), 32'd15);
        applyStimulus(0, 32'd0, 32'd0, 1, 1'b0);
        checkOutput("t2_ready_back", 32'(iq_ready), 32'd1);
        applyStimulus(2, seq, seq + 1, 0, 1'b0);
        seq = seq + 2;
        checkOutput("t2_full16", 32'(iq_size), 32'd16);
        checkOutput("t2_req0_order", issue_require[0], 32'h101);

        // Flush with push and pop in the same cycle.
        applyStimulus(2, 32'hF0, 32'hF1, 2, 1'b1);
        pinState("t2_flush", 0, 1'b1, 32'd0, 32'd0);

        // Steady state at four entries with push 2 / pop 2, wrapping pointers.
        applyStimulus(2, 32'h500, 32'h501, 0, 1'b0);
        applyStimulus(2, 32'h502, 32'h503, 0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(2, 32'h504 + 32'(2 * i), 32'h505 + 32'(2 * i), 2, 1'b0);
            checkOutput("t3_size", 32'(iq_size), 32'd4);
        end
        checkOutput("t3_req0", issue_require[0], 32'h528);
        checkOutput("t3_req1", issue_require[1], 32'h529);

        // Over-requested pop at one entry, with and without a simultaneous push.
        applyStimulus(0, 32'd0, 32'd0, 2, 1'b1);
        applyStimulus(1, 32'h600, 32'd0, 0, 1'b0);
        applyStimulus(0, 32'd0, 32'd0, 2, 1'b0);
        pinState("t4_clamp", 0, 1'b1, 32'd0, 32'd0);
        applyStimulus(1, 32'h601, 32'd0, 0, 1'b0);
        applyStimulus(2, 32'h602, 32'h603, 2, 1'b0);
        pinState("t4_pushpop", 2, 1'b1, 32'h602, 32'h603);

        // Flush at seven entries.
        applyStimulus(2, 32'h700, 32'h701, 0, 1'b0);
        applyStimulus(2, 32'h702, 32'h703, 0, 1'b0);
        applyStimulus(1, 32'h704, 32'd0, 0, 1'b0);
        checkOutput("t5_size7", 32'(iq_size), 32'd7);
        applyStimulus(2, 32'h7F0, 32'h7F1, 2, 1'b1);
        pinState("t5_flush", 0, 1'b1, 32'd0, 32'd0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(int'($urandom_range(0, 3)), $urandom, $urandom,
                          int'($urandom_range(0, 3)), ($urandom_range(0, 31) == 0));
        end

        // Asynchronous reset at nine entries, between clock edges.
        applyStimulus(0, 32'd0, 32'd0, 2, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(2, 32'h900 + 32'(i), 32'h980 + 32'(i), 0, 1'b0);
        applyStimulus(1, 32'h9FF, 32'd0, 0, 1'b0);
        checkOutput("t6_size9", 32'(iq_size), 32'd9);
        #2;
        push_number = 2'd2; iq_pop_number = 2'd1;
        rst = 1'b0;
        #1;
        pinState("t6_async", 0, 1'b1, 32'd0, 32'd0);
`ifdef ISSUE_QUEUE_STAT_EN
        checkOutput("t6_stat_full", stat_full_cycles, 32'd0);
        checkOutput("t6_stat_issued", stat_issued, 32'd0);
`endif
        @(posedge clk);
        #1;
        push_number = 2'd0; iq_pop_number = 2'd0;
        rst = 1'b1;
        applyStimulus(2, 32'hA00, 32'hA01, 0, 1'b0);
        pinState("t6_after", 2, 1'b1, 32'hA00, 32'hA01);
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
